axi_ram_slave: RTL and testbench
================================

// Module: axi_ram_slave
// PURPOSE
//  AXI3 slave that responds to the cache-side AXI master: it accepts read and write bursts and
//  serves them from an internal word-addressed RAM. Used as the memory endpoint in block-level
//  and SoC-lite simulation, and as on-chip scratch RAM. Read and write channels run independently.
// PARAMETERS
//  AW        12  word-index bits; RAM depth = 2**AW 32-bit words
//  RD_DELAY  2   idle cycles between AR handshake and first R beat (0..15)
// PORTS
//  clk          in   1   clock; one clock domain
//  reset        in   1   synchronous, active-high reset
//  axi_arid     in   4   read ID          | axi_araddr  in 32 | axi_arlen in 8 | axi_arsize in 3
//  axi_arburst  in   2   INCR only        | axi_arvalid in 1  | axi_arready out 1
//  axi_rid      out  4   = latched arid   | axi_rdata  out 32 | axi_rresp out 2 | axi_rlast out 1
//  axi_rvalid   out  1                    | axi_rready  in 1
//  axi_awid     in   4   write ID         | axi_awaddr  in 32 | axi_awlen in 8 | axi_awsize in 3
//  axi_awburst  in   2   INCR only        | axi_awvalid in 1  | axi_awready out 1
//  axi_wid      in   4   ignored          | axi_wdata   in 32 | axi_wstrb in 4 | axi_wlast in 1
//  axi_wvalid   in   1                    | axi_wready out 1
//  axi_bid      out  4   = latched awid   | axi_bresp  out 2  | axi_bvalid out 1 | axi_bready in 1
//  (arlock/arcache/arprot/awlock/awcache/awprot inputs accepted and ignored)
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high. All valid/ready outputs 0 except
//   arready=awready=1 the cycle after reset; rid/bid/rresp/bresp/rdata/rlast 0. RAM is NOT cleared.
//   Reset mid-burst abandons the burst: FSMs -> IDLE, no further R/B beats.
//  Addressing: word index = addr[AW+1:2]; upper bits alias. Beat n address = start + n*4,
//   wrapping modulo 2**AW words. Size is ignored for addressing: narrow beats return/write the
//   full aligned word; lane selection is by wstrb only.
//  Read FSM: R_IDLE -> R_WAIT -> R_BURST -> R_IDLE.
//   R_IDLE: arready=1; on arvalid latch id/addr/len, load delay counter = RD_DELAY.
//   R_WAIT: counter decrements each cycle; leave when 0 (RD_DELAY=0 skips R_WAIT).
//   R_BURST: rvalid=1, rdata=mem[beat addr] (combinational read), rresp=OKAY,
//    rlast=1 when beat count == arlen. On rvalid&rready: count++, addr+4; after last beat -> R_IDLE.
//   rready low: rdata/rlast/rid held stable. First rvalid is RD_DELAY+1 cycles after AR handshake.
//  Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   W_IDLE: awready=1, wready=0 (W before AW is stalled, not buffered); latch id/addr/len.
//   W_DATA: wready=1; each wvalid beat writes bytes with wstrb[i]=1 at edge; count++, addr+4.
//    Burst ends on wlast; bresp = OKAY(00) if beats == awlen+1 else SLVERR(10). Beats past awlen
//    without wlast are accepted and discarded (no RAM write).
//   W_RESP: bvalid=1 until bready; -> W_IDLE. awready stays 0 until B handshake completes.
//  Same-word read/write collision in one cycle: the R beat shows pre-write data; the write lands.
//  arburst/awburst != INCR: treated as INCR. rresp always OKAY.
// TESTING
//  1 Reset: after reset=1 one cycle -> arready=awready=1, rvalid=wready=bvalid=0.
//  2 Write burst awaddr=0x100 awlen=3, wdata 0xA0..0xA3, wstrb=F, wlast on beat 3 -> bvalid,
//    bresp=00, bid=awid; read back arlen=3 -> rdata A0,A1,A2,A3, rlast only on 4th beat.
//  3 Partial strobe: word 0x200=0x11223344, write 0xAABBCCDD wstrb=0101 -> read 0x11BB33DD.
//  4 Read latency/backpressure: RD_DELAY=2, AR at cycle t -> rvalid first at t+3; rready low
//    2 cycles mid-burst -> rdata held, no beat skipped.
//  5 Wrap: AW=12, araddr=0x3FF8 arlen=3 -> words 0xFFE,0xFFF,0x000,0x001.
//  6 Error/abort: wlast on beat 1 with awlen=3 -> bresp=10; reset asserted mid-read -> rvalid 0
//    next cycle, arready 1, no further beats.

Source files
------------

// File: rtl/axi_ram_slave_if.sv
// AXI3 bus bundle between the cache-side master and the RAM slave.
// Read (AR/R) and write (AW/W/B) channels are independent.
interface axi_ram_slave_if;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [1:0]  axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;

  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [1:0]  axi_awlock;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;

  logic [3:0]  axi_wid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;

  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready
  );

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 slave serving INCR bursts from a word-addressed RAM; first R beat RD_DELAY+1 cycles
// after AR, R/B held under backpressure, W stalled until AW is taken.
module axi_ram_slave #(
  parameter int AW       = 12,
  parameter int RD_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset,
  axi_ram_slave_if.slave axi
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // R_WAIT exits when the counter is already zero, so one less than the delay is loaded.
  localparam logic [3:0] LP_DLY_LOAD = (RD_DELAY == 0) ? 4'd0 : 4'(RD_DELAY - 1);
  localparam logic [AW-1:0] LP_ONE = AW'(1);

  logic [31:0] r_mem [1<<AW];

  rstate_t     r_rstate;
  logic        r_arready, r_rvalid, r_rlast;
  logic [3:0]  r_rid, r_dly;
  logic [AW-1:0] r_raddr;
  logic [7:0]  r_rlen, r_rcnt;

  wstate_t     r_wstate;
  logic        r_awready, r_wready, r_bvalid;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [AW-1:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [8:0]  r_wcnt;

  logic w_we;
  logic w_unused_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_dly     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (axi.axi_arvalid && r_arready) begin
          r_rid     <= axi.axi_arid;
          r_raddr   <= axi.axi_araddr[AW+1:2];
          r_rlen    <= axi.axi_arlen;
          r_rcnt    <= '0;
          r_arready <= 1'b0;
          if (RD_DELAY == 0) begin
            r_rstate <= R_BURST;
            r_rvalid <= 1'b1;
            r_rlast  <= (axi.axi_arlen == 8'd0);
          end else begin
            r_rstate <= R_WAIT;
            r_dly    <= LP_DLY_LOAD;
          end
        end
        R_WAIT: if (r_dly == 4'd0) begin
          r_rstate <= R_BURST;
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rlen == 8'd0);
        end else begin
          r_dly <= r_dly - 4'd1;
        end
        R_BURST: if (axi.axi_rready) begin
          if (r_rlast) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
          end else begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_raddr <= r_raddr + LP_ONE;
            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (axi.axi_awvalid && r_awready) begin
          r_bid     <= axi.axi_awid;
          r_waddr   <= axi.axi_awaddr[AW+1:2];
          r_wlen    <= axi.axi_awlen;
          r_wcnt    <= '0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (axi.axi_wvalid) begin
          if (axi.axi_wlast) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= (r_wcnt == {1'b0, r_wlen}) ? 2'b00 : 2'b10;
            r_wstate <= W_RESP;
          end else begin
            // Saturate so a runaway burst never wraps back into the write window.
            if (r_wcnt != 9'h1FF) r_wcnt <= r_wcnt + 9'd1;
            r_waddr <= r_waddr + LP_ONE;
          end
        end
        W_RESP: if (axi.axi_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_we = !reset && (r_wstate == W_DATA) && axi.axi_wvalid && (r_wcnt <= {1'b0, r_wlen});

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.axi_wstrb[i]) r_mem[r_waddr][8*i +: 8] <= axi.axi_wdata[8*i +: 8];
      end
    end
  end

  assign axi.axi_arready = r_arready;
  assign axi.axi_rid     = r_rid;
  assign axi.axi_rdata   = r_rvalid ? r_mem[r_raddr] : 32'd0;
  assign axi.axi_rresp   = 2'b00;
  assign axi.axi_rlast   = r_rlast;
  assign axi.axi_rvalid  = r_rvalid;
  assign axi.axi_awready = r_awready;
  assign axi.axi_wready  = r_wready;
  assign axi.axi_bid     = r_bid;
  assign axi.axi_bresp   = r_bresp;
  assign axi.axi_bvalid  = r_bvalid;

  assign w_unused_ok = ^{axi.axi_araddr[31:AW+2], axi.axi_araddr[1:0], axi.axi_arsize,
                         axi.axi_arburst, axi.axi_arlock, axi.axi_arcache, axi.axi_arprot,
                         axi.axi_awaddr[31:AW+2], axi.axi_awaddr[1:0], axi.axi_awsize,
                         axi.axi_awburst, axi.axi_awlock, axi.axi_awcache, axi.axi_awprot,
                         axi.axi_wid};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: bursts, strobes, latency, backpressure, wrap, errors, reset.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_d [0:7];

  axi_ram_slave_if bus();

  axi_ram_slave #(.AW(12), .RD_DELAY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .axi   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input logic [31:0] base, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    int t;
    t = 0;
    while (!bus.axi_awready && t < 50) begin step(); t++; end
    if (t >= 50) chk("aw_tmo", 32'd0, 32'd1);
    bus.axi_awid = id; bus.axi_awaddr = addr; bus.axi_awlen = len;
    bus.axi_awsize = 3'd2; bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b1;
    step();
    bus.axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.axi_wdata = base + 32'(i);
      bus.axi_wstrb = strb;
      bus.axi_wlast = (i == nbeats - 1);
      bus.axi_wvalid = 1'b1;
      t = 0;
      while (!bus.axi_wready && t < 50) begin step(); t++; end
      if (t >= 50) chk("w_tmo", 32'd0, 32'd1);
      step();
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast = 1'b0;
    t = 0;
    while (!bus.axi_bvalid && t < 50) begin step(); t++; end
    if (t >= 50) chk("b_tmo", 32'd0, 32'd1);
    chk("bresp", 32'(bus.axi_bresp), 32'(exp_resp));
    chk("bid", 32'(bus.axi_bid), 32'(id));
    bus.axi_bready = 1'b1;
    step();
    bus.axi_bready = 1'b0;
    chk("b_clr", 32'(bus.axi_bvalid), 32'd0);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int stall_at);
    int t;
    int lat;
    t = 0;
    while (!bus.axi_arready && t < 50) begin step(); t++; end
    if (t >= 50) chk("ar_tmo", 32'd0, 32'd1);
    bus.axi_arid = id; bus.axi_araddr = addr; bus.axi_arlen = len;
    bus.axi_arsize = 3'd2; bus.axi_arburst = 2'b01; bus.axi_arvalid = 1'b1;
    step();
    bus.axi_arvalid = 1'b0;
    lat = 1;
    while (!bus.axi_rvalid && lat < 50) begin step(); lat++; end
    chk("r_lat", 32'(lat), 32'd3);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!bus.axi_rvalid && t < 50) begin step(); t++; end
      if (t >= 50) chk("r_tmo", 32'd0, 32'd1);
      chk("rdata", bus.axi_rdata, exp_d[i]);
      chk("rlast", 32'(bus.axi_rlast), (i == int'(len)) ? 32'd1 : 32'd0);
      chk("rid", 32'(bus.axi_rid), 32'(id));
      if (i == stall_at) begin
        bus.axi_rready = 1'b0;
        repeat (2) begin
          step();
          chk("r_hold_vld", 32'(bus.axi_rvalid), 32'd1);
          chk("r_hold_dat", bus.axi_rdata, exp_d[i]);
        end
      end
      bus.axi_rready = 1'b1;
      step();
      bus.axi_rready = 1'b0;
    end
    chk("r_end_vld", 32'(bus.axi_rvalid), 32'd0);
    chk("r_end_ardy", 32'(bus.axi_arready), 32'd1);
  endtask

  initial begin
    int t;
    bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = '0;
    bus.axi_arburst = '0; bus.axi_arlock = '0; bus.axi_arcache = '0; bus.axi_arprot = '0;
    bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
    bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = '0;
    bus.axi_awburst = '0; bus.axi_awlock = '0; bus.axi_awcache = '0; bus.axi_awprot = '0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wid = '0; bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0;
    bus.axi_wvalid = 1'b0; bus.axi_bready = 1'b0;

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_arready", 32'(bus.axi_arready), 32'd1);
    chk("rst_awready", 32'(bus.axi_awready), 32'd1);
    chk("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
    chk("rst_wready", 32'(bus.axi_wready), 32'd0);
    chk("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
    chk("rst_rlast", 32'(bus.axi_rlast), 32'd0);

    // Full-strobe burst then read back.
    wr_burst(4'h3, 32'h100, 8'd3, 4, 32'hA0, 4'hF, 2'b00);
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    rd_burst(4'h5, 32'h100, 8'd3, -1);

    // Partial strobe merge.
    wr_burst(4'h1, 32'h200, 8'd0, 1, 32'h11223344, 4'hF, 2'b00);
    wr_burst(4'h1, 32'h200, 8'd0, 1, 32'hAABBCCDD, 4'b0101, 2'b00);
    exp_d[0] = 32'h11BB33DD;
    rd_burst(4'h2, 32'h200, 8'd0, -1);

    // Backpressure mid-burst.
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    rd_burst(4'h6, 32'h100, 8'd3, 1);

    // Wrap at the top of the word space.
    wr_burst(4'h7, 32'h3FF8, 8'd3, 4, 32'hC0, 4'hF, 2'b00);
    exp_d[0] = 32'hC0; exp_d[1] = 32'hC1; exp_d[2] = 32'hC2; exp_d[3] = 32'hC3;
    rd_burst(4'h8, 32'h3FF8, 8'd3, -1);
    exp_d[0] = 32'hC2; exp_d[1] = 32'hC3;
    rd_burst(4'h8, 32'h0, 8'd1, -1);

    // Extra beat beyond awlen is discarded and flagged.
    wr_burst(4'h0, 32'h304, 8'd0, 1, 32'h77, 4'hF, 2'b00);
    wr_burst(4'h0, 32'h300, 8'd0, 2, 32'h55, 4'hF, 2'b10);
    exp_d[0] = 32'h55; exp_d[1] = 32'h77;
    rd_burst(4'h4, 32'h300, 8'd1, -1);

    // Early wlast.
    wr_burst(4'h9, 32'h400, 8'd3, 2, 32'hE0, 4'hF, 2'b10);

    // Reset in the middle of a read burst.
    bus.axi_arid = 4'hA; bus.axi_araddr = 32'h100; bus.axi_arlen = 8'd3; bus.axi_arvalid = 1'b1;
    step();
    bus.axi_arvalid = 1'b0;
    t = 0;
    while (!bus.axi_rvalid && t < 50) begin step(); t++; end
    chk("abort_first", bus.axi_rdata, 32'hA0);
    bus.axi_rready = 1'b1;
    step();
    bus.axi_rready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rvalid", 32'(bus.axi_rvalid), 32'd0);
    chk("abort_arready", 32'(bus.axi_arready), 32'd1);
    bus.axi_rready = 1'b1;
    repeat (5) step();
    bus.axi_rready = 1'b0;
    chk("abort_quiet", 32'(bus.axi_rvalid), 32'd0);

    // RAM contents survive reset.
    exp_d[0] = 32'hA0;
    rd_burst(4'hB, 32'h100, 8'd0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
